vga_timing_gen: RTL
===================

Name: vga_timing_gen

Overview:
- Generates 640x480@60 Hz VGA timing from the 100 MHz system clock.
- Produces the pixel counters h_cnt/v_cnt that the sprite address generators turn into ROM pixel_addr values.
- Produces hsync/vsync and a valid (display-enable) strobe for the pixel mux and the VGA pins.
- Sits directly upstream of all address-generator instances; one instance per design.

Parameters:
- CLK_DIV, 4, clk cycles per pixel (100 MHz / 4 = 25 MHz pixel rate); legal range 1..16.
- H_DISP, 640, visible pixels per line.
- H_FP, 16, horizontal front porch (pixels).
- H_SYNC, 96, hsync pulse width (pixels).
- H_BP, 48, horizontal back porch (pixels).
- V_DISP, 480, visible lines per frame.
- V_FP, 10, vertical front porch (lines).
- V_SYNC, 2, vsync pulse width (lines).
- V_BP, 33, vertical back porch (lines).

Ports:
- clk  in  1  system clock, 100 MHz.
- rst_n  in  1  asynchronous active-low reset.
- pclk_en  out  1  one-clk pixel tick, high once every CLK_DIV clk cycles.
- hsync  out  1  horizontal sync, active low.
- vsync  out  1  vertical sync, active low.
- valid  out  1  high while the current position is in the visible area.
- h_cnt  out  10  visible column 0..H_DISP-1; 0 when valid=0.
- v_cnt  out  10  visible line 0..V_DISP-1; 0 when valid=0.
- frame_start  out  1  one-clk pulse when position returns to (0,0).

Behaviour:
- Reset: one clock, clk; reset rst_n is asynchronous and active-low, all flops cleared while low.
- Reset values: div_cnt=0, h_pos=0, v_pos=0, pclk_en=0, hsync=1, vsync=1, valid=1, h_cnt=0, v_cnt=0, frame_start=0.
- Totals: H_TOTAL = H_DISP+H_FP+H_SYNC+H_BP = 800; V_TOTAL = 525. Both must be ≤1024; counters are 10 bits. Elaboration fails otherwise.
- Divider: div_cnt counts 0..CLK_DIV-1 and wraps.
- pclk_en: registered, high for exactly one clk when div_cnt==CLK_DIV-1. First pulse on the CLK_DIV-th edge after rst_n deasserts. CLK_DIV=1 gives pclk_en constantly high after the first edge.
- Horizontal position: on each pclk_en, h_pos increments. At H_TOTAL-1 it wraps to 0 and v_pos advances.
- Vertical position: v_pos wraps from V_TOTAL-1 to 0. The wrap happens in the same tick as the h wrap.
- Output registers: all outputs except pclk_en are flops. They load decodes of the next (h_pos,v_pos) on the clk edge where the counters move. All outputs therefore change together, only on tick edges, and always match the counters.
- hsync = 0 iff H_DISP+H_FP ≤ h_pos ≤ H_DISP+H_FP+H_SYNC-1 (656..751).
- vsync = 0 iff V_DISP+V_FP ≤ v_pos ≤ V_DISP+V_FP+V_SYNC-1 (490..491).
- valid = (h_pos < H_DISP) && (v_pos < V_DISP).
- h_cnt/v_cnt = h_pos/v_pos when valid, else 0. This keeps downstream address math inside ROM range during blanking.
- frame_start: high for one clk after the edge where the counters wrap (H_TOTAL-1, V_TOTAL-1) -> (0,0). Not asserted on reset release.
- Reset mid-frame: the asynchronous return to reset values is immediate, with no partial sync pulse held.

Optional Feature:
- Macro: VGA_FRAME_CNT_EN.
- Defined:
  - Adds output frame_cnt [7:0], reset 0.
  - Increments by 1 on the same edge that raises frame_start; wraps 255 -> 0.
  - Used by sprite animation.
- Undefined: port and register absent; all other behaviour identical.

Test Plan:
- Reset: hold rst_n=0 for 5 clk -> all outputs at reset values. Release -> first pclk_en on 4th clk edge; then h_cnt=1 on that tick.
- Line timing: run 1 line -> valid falls when h_pos=640 (h_cnt=0). hsync low from h_pos=656 to 751, i.e. exactly 96 ticks = 384 clk. h_pos wraps 799 -> 0 with v_cnt 0 -> 1.
- Frame timing: run 2 frames -> vsync low for exactly 2 lines (1600 ticks) at lines 490-491. frame_start pulses exactly 1 clk wide, 1,680,000 clk apart.
- Address safety: sample h_cnt/v_cnt every clk across 1 frame -> never exceed 639/479; both 0 whenever valid=0.
- Async reset mid-frame: assert rst_n at h_pos=700, v_pos=300 between clk edges -> outputs return to reset values without waiting for clk. Restart matches the first scenario.
- With VGA_FRAME_CNT_EN: run 257 frames -> frame_cnt reads 1 after the 257th frame_start (wrap verified). Without the macro -> the design compiles with no frame_cnt port.

Source files
------------

// File: rtl/vga_timing_gen_if.sv
// vga_timing_gen_if: timing bundle from the VGA timing generator to the
// address generators, pixel mux and VGA pins.
// Signals (driven by the master):
//   pclk_en     one-clk pixel tick
//   hsync       horizontal sync, active low
//   vsync       vertical sync, active low
//   valid       display enable
//   h_cnt       visible column, 0 in blanking
//   v_cnt       visible line, 0 in blanking
//   frame_start one-clk pulse on wrap to (0,0)
//   frame_cnt   8-bit frame counter, only with VGA_FRAME_CNT_EN
interface vga_timing_gen_if;
    logic       pclk_en;
    logic       hsync;
    logic       vsync;
    logic       valid;
    logic [9:0] h_cnt;
    logic [9:0] v_cnt;
    logic       frame_start;
`ifdef VGA_FRAME_CNT_EN
    logic [7:0] frame_cnt;
`endif

    modport master (
`ifdef VGA_FRAME_CNT_EN
        output frame_cnt,
`endif
        output pclk_en,
        output hsync,
        output vsync,
        output valid,
        output h_cnt,
        output v_cnt,
        output frame_start
    );

    modport slave (
`ifdef VGA_FRAME_CNT_EN
        input  frame_cnt,
`endif
        input  pclk_en,
        input  hsync,
        input  vsync,
        input  valid,
        input  h_cnt,
        input  v_cnt,
        input  frame_start
    );
endinterface

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: 640x480@60 VGA timing from the system clock.
// Ports:
//   clk    in   system clock
//   rst_n  in   asynchronous active-low reset
//   vga    master modport of vga_timing_gen_if carrying pclk_en, hsync,
//          vsync, valid, h_cnt, v_cnt, frame_start (and frame_cnt).
// Optional: define VGA_FRAME_CNT_EN to add the 8-bit frame_cnt output.
module vga_timing_gen #(
    parameter int CLK_DIV = 4,
    parameter int H_DISP  = 640,
    parameter int H_FP    = 16,
    parameter int H_SYNC  = 96,
    parameter int H_BP    = 48,
    parameter int V_DISP  = 480,
    parameter int V_FP    = 10,
    parameter int V_SYNC  = 2,
    parameter int V_BP    = 33
) (
    input  logic             clk,
    input  logic             rst_n,
    vga_timing_gen_if.master vga
);

    localparam int H_TOTAL = H_DISP + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_DISP + V_FP + V_SYNC + V_BP;
    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS  = 10'(H_DISP);
    localparam logic [9:0] V_VIS  = 10'(V_DISP);
    localparam logic [9:0] HS_BEG = 10'(H_DISP + H_FP);
    localparam logic [9:0] HS_END = 10'(H_DISP + H_FP + H_SYNC - 1);
    localparam logic [9:0] VS_BEG = 10'(V_DISP + V_FP);
    localparam logic [9:0] VS_END = 10'(V_DISP + V_FP + V_SYNC - 1);

    if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_total
        $error("vga_timing_gen: totals exceed 10-bit counters");
    end
    if (CLK_DIV < 1 || CLK_DIV > 16) begin : g_bad_div
        $error("vga_timing_gen: CLK_DIV outside 1..16");
    end

    logic [DW-1:0] r_div_cnt;
    logic          r_pclk_en;
    logic [9:0]    r_h_pos;
    logic [9:0]    r_v_pos;
    logic          r_hsync;
    logic          r_vsync;
    logic          r_valid;
    logic [9:0]    r_h_cnt;
    logic [9:0]    r_v_cnt;
    logic          r_frame_start;

    logic          w_tick;
    logic          w_h_last;
    logic          w_v_last;
    logic          w_wrap;
    logic [9:0]    w_h_nxt;
    logic [9:0]    w_v_nxt;
    logic          w_hsync_nxt;
    logic          w_vsync_nxt;
    logic          w_valid_nxt;

    // The tick is decoded from the divider so that counters and
    // decoded outputs move on the same edge that raises pclk_en.
    assign w_tick   = (r_div_cnt == DIV_LAST);
    assign w_h_last = (r_h_pos == H_LAST);
    assign w_v_last = (r_v_pos == V_LAST);
    assign w_wrap   = w_tick && w_h_last && w_v_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div_cnt <= '0;
            r_pclk_en <= 1'b0;
        end else begin
            r_pclk_en <= w_tick;
            if (w_tick) begin
                r_div_cnt <= '0;
            end else begin
                r_div_cnt <= r_div_cnt + DW'(1);
            end
        end
    end

    always_comb begin
        w_h_nxt = r_h_pos + 10'd1;
        w_v_nxt = r_v_pos;
        if (w_h_last) begin
            w_h_nxt = '0;
            if (w_v_last) begin
                w_v_nxt = '0;
            end else begin
                w_v_nxt = r_v_pos + 10'd1;
            end
        end
    end

    // Decodes of the position the counters are about to take, so the
    // registered outputs always agree with the registered counters.
    always_comb begin
        w_hsync_nxt = 1'b1;
        w_vsync_nxt = 1'b1;
        if (w_h_nxt >= HS_BEG && w_h_nxt <= HS_END) begin
            w_hsync_nxt = 1'b0;
        end
        if (w_v_nxt >= VS_BEG && w_v_nxt <= VS_END) begin
            w_vsync_nxt = 1'b0;
        end
        w_valid_nxt = (w_h_nxt < H_VIS) && (w_v_nxt < V_VIS);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_h_pos <= '0;
            r_v_pos <= '0;
            r_hsync <= 1'b1;
            r_vsync <= 1'b1;
            r_valid <= 1'b1;
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else if (w_tick) begin
            r_h_pos <= w_h_nxt;
            r_v_pos <= w_v_nxt;
            r_hsync <= w_hsync_nxt;
            r_vsync <= w_vsync_nxt;
            r_valid <= w_valid_nxt;
            // Zero in blanking keeps sprite ROM addresses in range.
            r_h_cnt <= w_valid_nxt ? w_h_nxt : 10'd0;
            r_v_cnt <= w_valid_nxt ? w_v_nxt : 10'd0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_frame_start <= 1'b0;
        end else begin
            r_frame_start <= w_wrap;
        end
    end

`ifdef VGA_FRAME_CNT_EN
    logic [7:0] r_frame_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_frame_cnt <= '0;
        end else if (w_wrap) begin
            r_frame_cnt <= r_frame_cnt + 8'd1;
        end
    end

    assign vga.frame_cnt = r_frame_cnt;
`endif

    assign vga.pclk_en     = r_pclk_en;
    assign vga.hsync       = r_hsync;
    assign vga.vsync       = r_vsync;
    assign vga.valid       = r_valid;
    assign vga.h_cnt       = r_h_cnt;
    assign vga.v_cnt       = r_v_cnt;
    assign vga.frame_start = r_frame_start;

endmodule
